sequence_player: RTL and testbench
==================================

SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 4: cycles each colour is shown (legal range 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: dark cycles after each colour (legal range 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  play request; high starts playback from IDLE; low aborts or releases.
REQ-006 SHALL have port sequence  input  32  packed colour sequence; colour k occupies bits [2k+1:2k]; colour 0 is played first.
REQ-007 SHALL have port sequence_len  input  4  number of colours to play, 0..15.
REQ-008 SHALL have port colour_on  output  1  high while a colour is being shown.
REQ-009 SHALL have port colour_val  output  2  colour being shown; 2'b00 whenever colour_on is low.
REQ-010 SHALL have port index  output  4  position k of the current colour; 0 when not playing.
REQ-011 SHALL have port busy  output  1  high in LOAD, SHOW and GAP.
REQ-012 SHALL have port complete_play  output  1  high in DONE.

Function
REQ-013 SHALL implement the states IDLE, LOAD, SHOW, GAP and DONE; all outputs SHALL be registered.
REQ-014 IDLE with en=1 at an edge: SHALL latch sequence and sequence_len internally and go to LOAD; later input changes SHALL be ignored until the next IDLE.
REQ-015 LOAD: if latched length = 0, SHALL go to DONE on the next edge; otherwise SHALL go to SHOW with index=0.
REQ-016 SHOW: colour_on=1 and colour_val=latched bits [2*index+1:2*index] for exactly ON_CYCLES consecutive cycles, then SHALL go to GAP.
REQ-017 GAP: colour_on=0 and colour_val=0 for exactly GAP_CYCLES cycles, then SHALL go to SHOW with index+1, or to DONE if index = latched length - 1.
REQ-018 Latency: first colour_on high SHALL be the 2nd cycle after the edge that samples en=1 in IDLE (one LOAD cycle intervenes).
REQ-019 Total playback for length L>0: SHALL be L*(ON_CYCLES+GAP_CYCLES) cycles from first colour_on to complete_play rising.
REQ-020 DONE: complete_play SHALL be held high while en=1; en=0 SHALL return to IDLE on the next edge, complete_play going low.
REQ-021 en=0 sampled in LOAD, SHOW or GAP: SHALL abort to IDLE on the next edge, clear all outputs and not assert complete_play.
REQ-022 Adjacent equal colours SHALL remain visibly separated by the GAP; no merging of SHOW periods.
REQ-023 Cycle counter SHALL be 8 bits wide, reload on every SHOW/GAP entry and never wrap; index SHALL never exceed 14.
REQ-024 Bits [31:30] of sequence SHALL be ignored.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, colour_on=0, colour_val=0, index=0, busy=0, complete_play=0, and clear the latched sequence, length and counter.
REQ-026 rst SHALL take priority over en in every state, including mid-SHOW and DONE.
REQ-027 After rst deasserts with en already high, playback SHALL start as in REQ-014 on the first edge without rst.

Verification
REQ-028 sequence=32'h000000FB, len=4, defaults, en held -> colour_val 3,2,3,3, each with 4 cycles on and 2 off; complete_play rises 24 cycles after the first colour_on.
REQ-029 len=0, en=1 -> busy for 1 cycle (LOAD), complete_play high the next cycle, colour_on never high.
REQ-030 len=15, sequence=32'hE4E4E4E4 -> colours 0,1,2,3 repeating, index reaches 14, bits [31:30] never shown, completes after 90 cycles.
REQ-031 en dropped during the 2nd SHOW of the REQ-028 stimulus -> all outputs 0 on the next cycle; complete_play stays 0; re-raising en restarts from index 0.
REQ-032 rst pulsed in GAP, and separately in DONE -> all outputs 0 on the next cycle; with en held, playback restarts from index 0 per REQ-027.
REQ-033 sequence input changed mid-playback -> the played colours match the values latched at start.

Source files
------------

// File: rtl/sequence_player.sv
// Plays a latched sequence of 2-bit colours: each is shown for ON_CYCLES, then
// followed by GAP_CYCLES dark cycles. Finishes in DONE until en is released.
module sequence_player #(
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    // "sequence" is a reserved word, hence the suffix on this one port
    input  logic [31:0] sequence_i,
    input  logic [3:0]  sequence_len,
    output logic        colour_on,
    output logic [1:0]  colour_val,
    output logic [3:0]  index,
    output logic        busy,
    output logic        complete_play,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SHOW = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] ON_RELOAD  = 8'(ON_CYCLES - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(GAP_CYCLES - 1);

    state_t      state_q;
    logic [29:0] seq_q;
    logic [3:0]  len_q;
    logic [7:0]  cnt_q;
    logic [3:0]  idx_q;
    logic        colour_on_q;
    logic [1:0]  colour_val_q;
    logic        busy_q;
    logic        complete_q;

    logic [3:0]  idx_next_d;
    logic [29:0] shifted_d;
    logic [1:0]  colour_next_d;
    logic        unused_seq_bits;

    assign unused_seq_bits = ^sequence_i[31:30];

    // Index and colour to present on the next SHOW entry (from LOAD or GAP).
    always_comb begin
        idx_next_d    = (state_q == S_GAP) ? idx_q + 4'd1 : 4'd0;
        shifted_d     = seq_q >> {idx_next_d, 1'b0};
        colour_next_d = shifted_d[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            seq_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            colour_on_q  <= 1'b0;
            colour_val_q <= 2'b00;
            busy_q       <= 1'b0;
            complete_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        seq_q   <= sequence_i[29:0];
                        len_q   <= sequence_len;
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (len_q == 4'd0) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        complete_q <= 1'b1;
                    end else begin
                        state_q      <= S_SHOW;
                        idx_q        <= idx_next_d;
                        cnt_q        <= ON_RELOAD;
                        colour_on_q  <= 1'b1;
                        colour_val_q <= colour_next_d;
                    end
                end
                S_SHOW: begin
                    if (!en) begin
                        state_q      <= S_IDLE;
                        idx_q        <= '0;
                        cnt_q        <= '0;
                        colour_on_q  <= 1'b0;
                        colour_val_q <= 2'b00;
                        busy_q       <= 1'b0;
                    end else if (cnt_q == 8'd0) begin
                        state_q      <= S_GAP;
                        cnt_q        <= GAP_RELOAD;
                        colour_on_q  <= 1'b0;
                        colour_val_q <= 2'b00;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_GAP: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (idx_q == len_q - 4'd1) begin
                        state_q    <= S_DONE;
                        idx_q      <= '0;
                        busy_q     <= 1'b0;
                        complete_q <= 1'b1;
                    end else begin
                        state_q      <= S_SHOW;
                        idx_q        <= idx_next_d;
                        cnt_q        <= ON_RELOAD;
                        colour_on_q  <= 1'b1;
                        colour_val_q <= colour_next_d;
                    end
                end
                S_DONE: begin
                    if (!en) begin
                        state_q    <= S_IDLE;
                        complete_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    idx_q        <= '0;
                    cnt_q        <= '0;
                    colour_on_q  <= 1'b0;
                    colour_val_q <= 2'b00;
                    busy_q       <= 1'b0;
                    complete_q   <= 1'b0;
                end
            endcase
        end
    end

    assign colour_on     = colour_on_q;
    assign colour_val    = colour_val_q;
    assign index         = idx_q;
    assign busy          = busy_q;
    assign complete_play = complete_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: directed scenarios plus randomized play/abort/reset
// traffic, checked every cycle against an expected-output timeline model.
module tb_sequence_player;

    localparam int ON  = 4;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] seq;
    logic [3:0]  len;
    logic        colour_on;
    logic [1:0]  colour_val;
    logic [3:0]  index;
    logic        busy;
    logic        complete_play;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    sequence_player #(.ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sequence_i   (seq),
        .sequence_len (len),
        .colour_on    (colour_on),
        .colour_val   (colour_val),
        .index        (index),
        .busy         (busy),
        .complete_play(complete_play),
        .dbg_state    (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected output word: {complete, busy, index[3:0], on, val[1:0]}
    logic [8:0] exp_q[$];
    logic [8:0] exp_now;
    int         mode;   // 0 idle, 1 playing (load/show/gap), 2 done

    function automatic logic [8:0] out_word(input logic c, input logic b,
                                            input logic [3:0] i, input logic o,
                                            input logic [1:0] v);
        return {c, b, i, o, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Playback timeline: each colour k is ON shown cycles then GAP dark cycles.
    task automatic model_edge(input logic r, input logic e);
        logic [31:0] s;
        logic [1:0]  c;
        if (r) begin
            exp_q.delete();
            mode    = 0;
            exp_now = '0;
        end else if (mode == 0) begin
            if (e) begin
                exp_q.delete();
                s = seq;
                for (int k = 0; k < int'(len); k++) begin
                    c = 2'((s >> (2 * k)) & 32'h3);
                    for (int j = 0; j < ON; j++)  exp_q.push_back(out_word(1'b0, 1'b1, 4'(k), 1'b1, c));
                    for (int j = 0; j < GAP; j++) exp_q.push_back(out_word(1'b0, 1'b1, 4'(k), 1'b0, 2'b00));
                end
                mode    = 1;
                exp_now = out_word(1'b0, 1'b1, 4'd0, 1'b0, 2'b00);
            end else begin
                exp_now = '0;
            end
        end else if (!e) begin
            exp_q.delete();
            mode    = 0;
            exp_now = '0;
        end else if (mode == 1 && exp_q.size() > 0) begin
            exp_now = exp_q.pop_front();
        end else begin
            mode    = 2;
            exp_now = out_word(1'b1, 1'b0, 4'd0, 1'b0, 2'b00);
        end
    endtask

    task automatic cycle(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        model_edge(r, e);
        check("outs", {23'd0, complete_play, busy, index, colour_on, colour_val}, {23'd0, exp_now});
    endtask

    // Plays with en held until complete_play; reports cycles from first on to done.
    task automatic play_measure(output int first_on, output int done_at, output int max_idx);
        first_on = -1;
        done_at  = -1;
        max_idx  = 0;
        cycle(1'b0, 1'b1);
        for (int t = 1; t <= 200 && done_at < 0; t++) begin
            cycle(1'b0, 1'b1);
            if (colour_on && first_on < 0) first_on = t;
            if (complete_play) done_at = t;
            if (int'(index) > max_idx) max_idx = int'(index);
        end
    endtask

    task automatic release_en();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    initial begin
        int first_on, done_at, max_idx, guard;
        logic seen_on;
        rst = 1'b1; en = 1'b0; seq = '0; len = '0;
        mode = 0; exp_now = '0;

        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("rst_busy", busy, 0);
        check("rst_complete", complete_play, 0);
        release_en();

        // Reference pattern: 3,2,3,3
        seq = 32'h0000_00FB; len = 4'd4;
        play_measure(first_on, done_at, max_idx);
        check("latency_first_on", first_on, 1);
        check("play_cycles_len4", done_at - first_on, 24);
        cycle(1'b0, 1'b1);
        check("done_held", complete_play, 1);
        release_en();
        check("done_release", complete_play, 0);

        // Zero length: one LOAD cycle then DONE
        seq = $urandom(); len = 4'd0;
        cycle(1'b0, 1'b1);
        check("len0_load_busy", busy, 1);
        cycle(1'b0, 1'b1);
        check("len0_complete", complete_play, 1);
        check("len0_busy_low", busy, 0);
        release_en();

        // Maximum length, top two bits of the pattern never shown
        seq = 32'hE4E4_E4E4; len = 4'd15;
        play_measure(first_on, done_at, max_idx);
        check("play_cycles_len15", done_at - first_on, 90);
        check("max_index", max_idx, 14);
        release_en();

        // Abort during the second SHOW, then restart from index 0
        seq = 32'h0000_00FB; len = 4'd4;
        cycle(1'b0, 1'b1);
        guard = 0;
        while (!(colour_on && index == 4'd1) && guard < 40) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        check("reach_second_show", guard < 40, 1);
        cycle(1'b0, 1'b0);
        check("abort_outputs", {complete_play, busy, index, colour_on, colour_val}, 0);
        cycle(1'b0, 1'b0);
        play_measure(first_on, done_at, max_idx);
        check("restart_play_cycles", done_at - first_on, 24);
        release_en();

        // Reset in GAP with en held, then reset in DONE
        cycle(1'b0, 1'b1);
        seen_on = 1'b0;
        guard   = 0;
        while (!(seen_on && !colour_on) && guard < 40) begin
            cycle(1'b0, 1'b1);
            if (colour_on) seen_on = 1'b1;
            guard++;
        end
        check("reach_gap", guard < 40, 1);
        cycle(1'b1, 1'b1);
        check("rst_in_gap", {complete_play, busy, index, colour_on, colour_val}, 0);
        play_measure(first_on, done_at, max_idx);
        check("play_after_gap_rst", done_at - first_on, 24);
        cycle(1'b1, 1'b1);
        check("rst_in_done", {complete_play, busy, index, colour_on, colour_val}, 0);
        play_measure(first_on, done_at, max_idx);
        check("play_after_done_rst", done_at - first_on, 24);
        release_en();

        // Input pattern scrambled during playback must not affect output
        seq = 32'h1234_5678; len = 4'd7;
        cycle(1'b0, 1'b1);
        for (int t = 0; t < 60; t++) begin
            seq = $urandom();
            len = 4'($urandom_range(0, 15));
            cycle(1'b0, 1'b1);
        end
        check("scrambled_done", complete_play, 1);
        release_en();

        // Randomized play / abort / reset traffic
        for (int it = 0; it < 40; it++) begin
            int hold;
            seq  = $urandom();
            len  = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 110);
            for (int t = 0; t < hold; t++) begin
                if ($urandom_range(0, 3) == 0) seq = $urandom();
                cycle($urandom_range(0, 79) == 0, 1'b1);
            end
            for (int t = 0; t < int'($urandom_range(1, 3)); t++) cycle(1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
